// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store front end for a word-addressed doubleword memory.
// It takes one byte-addressed request at a time, checks alignment, range and funct3.
// Sub-doubleword stores become read-modify-write sequences.
// Load data is extracted and sign/zero-extended.
// The response is registered, so resp_valid rises in the cycle after the RESP state.
module mem_access_unit #(
    parameter int XLEN       = 64,
    parameter int MEM_AWIDTH = 16,
    parameter int ADDRSIZE   = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [ADDRSIZE-1:0]   req_addr,
    input  logic [XLEN-1:0]       req_wdata,
    output logic                  resp_valid,
    output logic                  resp_err,
    output logic [XLEN-1:0]       resp_rdata,
    output logic                  mem_wren,
    output logic                  mem_rden,
    output logic [MEM_AWIDTH-1:0] mem_addr,
    output logic [XLEN-1:0]       mem_d,
    input  logic [XLEN-1:0]       mem_q
);
    localparam int NBYTES = XLEN / 8;

    typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

    state_t                state_reg, state_next;
    logic [2:0]            funct3_reg;
    logic [2:0]            off_reg;
    logic                  we_reg;
    logic                  err_reg;
    logic [XLEN-1:0]       wdata_reg;
    logic [XLEN-1:0]       load_reg;
    logic [MEM_AWIDTH-1:0] mem_addr_reg;
    logic [XLEN-1:0]       mem_d_reg;
    logic                  resp_valid_reg;
    logic                  resp_err_reg;
    logic [XLEN-1:0]       resp_rdata_reg;

    logic                  accept;
    logic                  misaligned;
    logic                  illegal;
    logic                  out_of_range;
    logic                  req_err;
    logic                  req_full_store;
    logic [XLEN-1:0]       q_shifted;
    logic [XLEN-1:0]       load_ext;
    logic [NBYTES-1:0]     size_mask;
    logic [NBYTES-1:0]     byte_en;
    logic [XLEN-1:0]       wdata_shifted;
    logic [XLEN-1:0]       merged;

    assign req_ready  = (state_reg == IDLE);
    assign accept     = req_valid && (state_reg == IDLE);
    assign mem_addr   = mem_addr_reg;
    assign mem_d      = mem_d_reg;
    assign resp_valid = resp_valid_reg;
    assign resp_err   = resp_err_reg;
    assign resp_rdata = resp_rdata_reg;

    // Alignment requirement depends only on the access size in funct3[1:0].
    always_comb begin
        misaligned = 1'b0;
        case (req_funct3[1:0])
            2'b01:   misaligned = req_addr[0];
            2'b10:   misaligned = |req_addr[1:0];
            2'b11:   misaligned = |req_addr[2:0];
            default: misaligned = 1'b0;
        endcase
    end

    // 111 is never legal; unsigned variants (1xx) make no sense for stores.
    assign illegal        = (req_funct3 == 3'b111) || (req_we && req_funct3[2]);
    assign out_of_range   = |req_addr[ADDRSIZE-1:MEM_AWIDTH+3];
    assign req_err        = misaligned || illegal || out_of_range;
    // A full doubleword store needs no read, so it goes straight to WR.
    assign req_full_store = req_we && (req_funct3[1:0] == 2'b11);

    // Next-state decode; memory strobes are pure functions of the state.
    always_comb begin
        state_next = state_reg;
        mem_wren   = 1'b0;
        mem_rden   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    if (req_err)             state_next = RESP;
                    else if (req_full_store) state_next = WR;
                    else                     state_next = RD;
                end
            end
            RD: begin
                mem_rden   = 1'b1;
                state_next = we_reg ? WR : RESP;
            end
            WR: begin
                mem_wren   = 1'b1;
                state_next = RESP;
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register; reset abandons any in-flight request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    // Bring the addressed lane down to bit 0, then extend per funct3.
    assign q_shifted = mem_q >> {off_reg, 3'b000};

    // Load extension: bit 2 of funct3 selects zero-extension.
    always_comb begin
        load_ext = q_shifted;
        case (funct3_reg)
            3'b000:  load_ext = {{(XLEN-8){q_shifted[7]}},   q_shifted[7:0]};
            3'b001:  load_ext = {{(XLEN-16){q_shifted[15]}}, q_shifted[15:0]};
            3'b010:  load_ext = {{(XLEN-32){q_shifted[31]}}, q_shifted[31:0]};
            3'b100:  load_ext = {{(XLEN-8){1'b0}},  q_shifted[7:0]};
            3'b101:  load_ext = {{(XLEN-16){1'b0}}, q_shifted[15:0]};
            3'b110:  load_ext = {{(XLEN-32){1'b0}}, q_shifted[31:0]};
            default: load_ext = q_shifted;
        endcase
    end

    // Byte mask of the access size before it is moved to the addressed lane.
    always_comb begin
        size_mask = NBYTES'(1);
        case (funct3_reg[1:0])
            2'b00:   size_mask = NBYTES'(8'h01);
            2'b01:   size_mask = NBYTES'(8'h03);
            2'b10:   size_mask = NBYTES'(8'h0F);
            default: size_mask = {NBYTES{1'b1}};
        endcase
    end

    // Alignment has already been checked, so the shifted mask never wraps.
    assign byte_en       = size_mask << off_reg;
    assign wdata_shifted = wdata_reg << {off_reg, 3'b000};

    // Per-lane merge: addressed lanes take store data, the rest keep the read word.
    generate
        for (genvar gi = 0; gi < NBYTES; gi++) begin : g_merge
            assign merged[8*gi +: 8] = byte_en[gi] ? wdata_shifted[8*gi +: 8] : mem_q[8*gi +: 8];
        end
    endgenerate

    // Request latch, memory address/data hold registers and load capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            funct3_reg   <= '0;
            off_reg      <= '0;
            we_reg       <= 1'b0;
            err_reg      <= 1'b0;
            wdata_reg    <= '0;
            load_reg     <= '0;
            mem_addr_reg <= '0;
            mem_d_reg    <= '0;
        end else begin
            if (accept) begin
                funct3_reg <= req_funct3;
                off_reg    <= req_addr[2:0];
                we_reg     <= req_we;
                err_reg    <= req_err;
                wdata_reg  <= req_wdata;
                // Rejected requests never touch the memory pins.
                if (!req_err) begin
                    mem_addr_reg <= req_addr[MEM_AWIDTH+2:3];
                    if (req_full_store) mem_d_reg <= req_wdata;
                end
            end
            if (state_reg == RD) begin
                if (we_reg) mem_d_reg <= merged;
                else        load_reg  <= load_ext;
            end
        end
    end

    // Registered response: one-cycle pulse; rdata held until the next response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_valid_reg <= 1'b0;
            resp_err_reg   <= 1'b0;
            resp_rdata_reg <= '0;
        end else begin
            resp_valid_reg <= (state_reg == RESP);
            resp_err_reg   <= (state_reg == RESP) && err_reg;
            if (state_reg == RESP) resp_rdata_reg <= (err_reg || we_reg) ? '0 : load_reg;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Testbench for mem_access_unit.
// A behavioural doubleword memory sits behind the DUT.
// Stimulus pushes the expected responses into a queue.
// A negedge monitor pops that queue and compares each response.
module tb_mem_access_unit;
    localparam int XLEN       = 64;
    localparam int MEM_AWIDTH = 16;
    localparam int ADDRSIZE   = 64;

    logic                  clk;
    logic                  rst_n;
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [2:0]            req_funct3;
    logic [ADDRSIZE-1:0]   req_addr;
    logic [XLEN-1:0]       req_wdata;
    logic                  resp_valid;
    logic                  resp_err;
    logic [XLEN-1:0]       resp_rdata;
    logic                  mem_wren;
    logic                  mem_rden;
    logic [MEM_AWIDTH-1:0] mem_addr;
    logic [XLEN-1:0]       mem_d;
    logic [XLEN-1:0]       mem_q;

    typedef struct {
        string       name;
        logic        err;
        logic [63:0] rdata;
        int          cyc;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          compared   = 0;
    int          mismatched = 0;
    int          cyc        = 0;
    int          wren_count = 0;
    int          rden_count = 0;
    logic [15:0] last_wr_addr = '0;
    logic        overlap_seen = 1'b0;

    logic [63:0] mem_array [0:65535];

    mem_access_unit #(
        .XLEN(XLEN), .MEM_AWIDTH(MEM_AWIDTH), .ADDRSIZE(ADDRSIZE)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
        .mem_wren(mem_wren), .mem_rden(mem_rden), .mem_addr(mem_addr),
        .mem_d(mem_d), .mem_q(mem_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: combinational read while rden, write on the clock edge.
    assign mem_q = mem_rden ? mem_array[mem_addr] : 64'h0;
    always @(posedge clk) if (mem_wren) mem_array[mem_addr] <= mem_d;

    // Pin activity bookkeeping.
    always @(negedge clk) begin
        if (mem_wren) begin
            wren_count   = wren_count + 1;
            last_wr_addr = mem_addr;
        end
        if (mem_rden) rden_count = rden_count + 1;
        if (mem_wren && mem_rden) overlap_seen = 1'b1;
    end

    // Response monitor: every resp_valid must match the oldest expectation.
    always @(negedge clk) begin
        if (resp_valid) begin
            compared = compared + 1;
            if (exp_q.size() == 0) begin
                mismatched = mismatched + 1;
                $display("FAIL unexpected_resp: got err=%0b rdata=%h at cyc %0d, expected no response",
                         resp_err, resp_rdata, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                if (resp_err !== mon_e.err || resp_rdata !== mon_e.rdata || cyc != mon_e.cyc) begin
                    mismatched = mismatched + 1;
                    $display("FAIL %s: got err=%0b rdata=%h cyc=%0d, expected err=%0b rdata=%h cyc=%0d",
                             mon_e.name, resp_err, resp_rdata, cyc, mon_e.err, mon_e.rdata, mon_e.cyc);
                end else begin
                    $display("resp %s: err=%0b rdata=%h cyc=%0d", mon_e.name, resp_err, resp_rdata, cyc);
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        compared = compared + 1;
        if (got !== exp) begin
            mismatched = mismatched + 1;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end else begin
            $display("check %s: %h", name, got);
        end
    endtask

    // Present a request from a negedge, wait for ready, record the expectation at accept.
    task automatic issue(input string name, input bit we, input logic [2:0] f3,
                         input logic [63:0] addr, input logic [63:0] wd,
                         input bit want, input bit e_err, input logic [63:0] e_rd,
                         input int lat, input bit keep);
        int   guard;
        exp_t e;
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        guard = 0;
        while (!req_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (!req_ready) begin
            compared   = compared + 1;
            mismatched = mismatched + 1;
            $display("FAIL %s_accept: req_ready=%0b after %0d cycles, expected 1", name, req_ready, guard);
            req_valid = 1'b0;
            return;
        end
        if (want) begin
            e.name  = name;
            e.err   = e_err;
            e.rdata = e_rd;
            e.cyc   = cyc + lat;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        if (!keep) req_valid = 1'b0;
    endtask

    // Wait (bounded) until every expected response has been seen.
    task automatic drain(input string name);
        int guard;
        guard = 0;
        while (exp_q.size() != 0 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (exp_q.size() != 0) begin
            compared   = compared + 1;
            mismatched = mismatched + 1;
            $display("FAIL %s_drain: %0d responses missing, expected 0", name, exp_q.size());
            exp_q.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int          w0;
        int          r0;
        logic [63:0] word0;

        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = '0;
        req_wdata  = '0;
        repeat (3) @(negedge clk);
        check("rst_req_ready",  64'(req_ready),  64'h1);
        check("rst_resp_valid", 64'(resp_valid), 64'h0);
        check("rst_mem_wren",   64'(mem_wren),   64'h0);
        check("rst_mem_rden",   64'(mem_rden),   64'h0);
        check("rst_mem_addr",   64'(mem_addr),   64'h0);
        check("rst_resp_rdata", resp_rdata,      64'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: full doubleword store then load back.
        w0 = wren_count;
        issue("SD_0x10", 1'b1, 3'b011, 64'h10, 64'h1122334455667788, 1'b1, 1'b0, 64'h0, 3, 1'b0);
        drain("SD_0x10");
        check("SD_wren_count", 64'(wren_count - w0), 64'h1);
        check("SD_wr_addr", 64'(last_wr_addr), 64'h2);
        check("SD_word2", mem_array[2], 64'h1122334455667788);
        issue("LD_0x10", 1'b0, 3'b011, 64'h10, 64'h0, 1'b1, 1'b0, 64'h1122334455667788, 3, 1'b0);
        drain("LD_0x10");

        // 2: byte store merge and byte/half loads.
        issue("SB_0x13", 1'b1, 3'b000, 64'h13, 64'hFFFF_FFFF_FFFF_FFAB, 1'b1, 1'b0, 64'h0, 4, 1'b0);
        drain("SB_0x13");
        check("SB_word2", mem_array[2], 64'h11223344AB667788);
        issue("LB_0x13",  1'b0, 3'b000, 64'h13, 64'h0, 1'b1, 1'b0, 64'hFFFFFFFFFFFFFFAB, 3, 1'b0);
        issue("LBU_0x13", 1'b0, 3'b100, 64'h13, 64'h0, 1'b1, 1'b0, 64'h00000000000000AB, 3, 1'b0);
        issue("LHU_0x16", 1'b0, 3'b101, 64'h16, 64'h0, 1'b1, 1'b0, 64'h0000000000001122, 3, 1'b0);
        drain("loads_word2");

        // 3: word/half sign and zero extension.
        issue("SD_0x0", 1'b1, 3'b011, 64'h0, 64'h80000000_7FFF8001, 1'b1, 1'b0, 64'h0, 3, 1'b0);
        issue("LW_0x4",  1'b0, 3'b010, 64'h4, 64'h0, 1'b1, 1'b0, 64'hFFFFFFFF80000000, 3, 1'b0);
        issue("LWU_0x4", 1'b0, 3'b110, 64'h4, 64'h0, 1'b1, 1'b0, 64'h0000000080000000, 3, 1'b0);
        issue("LH_0x0",  1'b0, 3'b001, 64'h0, 64'h0, 1'b1, 1'b0, 64'hFFFFFFFFFFFF8001, 3, 1'b0);
        drain("loads_word0");

        // 4: error cases, no memory activity allowed.
        w0 = wren_count;
        r0 = rden_count;
        issue("ERR_LH_0x1",  1'b0, 3'b001, 64'h1, 64'h0, 1'b1, 1'b1, 64'h0, 2, 1'b0);
        issue("ERR_SW_0x6",  1'b1, 3'b010, 64'h6, 64'h5, 1'b1, 1'b1, 64'h0, 2, 1'b0);
        issue("ERR_f3_111",  1'b0, 3'b111, 64'h0, 64'h0, 1'b1, 1'b1, 64'h0, 2, 1'b0);
        issue("ERR_st_100",  1'b1, 3'b100, 64'h0, 64'h7, 1'b1, 1'b1, 64'h0, 2, 1'b0);
        issue("ERR_range",   1'b0, 3'b011, 64'h1 << (MEM_AWIDTH + 3), 64'h0, 1'b1, 1'b1, 64'h0, 2, 1'b0);
        drain("errors");
        check("ERR_wren_count", 64'(wren_count - w0), 64'h0);
        check("ERR_rden_count", 64'(rden_count - r0), 64'h0);

        // 5: asynchronous reset while the SH read is in flight.
        word0 = mem_array[0];
        w0    = wren_count;
        issue("SH_reset", 1'b1, 3'b001, 64'h2, 64'hBEEF, 1'b0, 1'b0, 64'h0, 4, 1'b0);
        check("RST_pre_rden", 64'(mem_rden), 64'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("RST_async_rden",  64'(mem_rden),   64'h0);
        check("RST_async_wren",  64'(mem_wren),   64'h0);
        check("RST_async_ready", 64'(req_ready),  64'h1);
        check("RST_async_mem_d", mem_d,           64'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        check("RST_after_ready", 64'(req_ready), 64'h1);
        check("RST_word0",       mem_array[0],   word0);
        check("RST_wren_count",  64'(wren_count - w0), 64'h0);

        // 6: back-to-back requests with req_valid held high.
        issue("B2B_SD_0x20", 1'b1, 3'b011, 64'h20, 64'hA1B2C3D4E5F60718, 1'b1, 1'b0, 64'h0, 3, 1'b1);
        issue("B2B_LD_0x20", 1'b0, 3'b011, 64'h20, 64'h0, 1'b1, 1'b0, 64'hA1B2C3D4E5F60718, 3, 1'b1);
        issue("B2B_SB_0x21", 1'b1, 3'b000, 64'h21, 64'h5A, 1'b1, 1'b0, 64'h0, 4, 1'b0);
        drain("b2b");
        check("B2B_word4", mem_array[4], 64'hA1B2C3D4E5F65A18);
        check("no_wren_rden_overlap", 64'(overlap_seen), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
